// File: rtl/mod_updown_counter.sv
// Synchronous modulo-N up/down counter with parallel load, clock-enable prescaler,
// wrap or saturate behaviour at the ends, and terminal-count / overflow flags.
module mod_updown_counter #(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter bit              SATURATE = 1'b0,
    parameter int              PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf,
    output logic             step
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam int               PCW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PCW-1:0]   PC_MAX  = PCW'(PRESCALE - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PCW-1:0]   prescaleCnt_q, prescaleCnt_d;
    logic             ovf_q, ovf_d;
    logic             atTop, atBottom, stepInt;

    assign atTop    = (count_q == MAX_VAL);
    assign atBottom = (count_q == '0);
    assign stepInt  = en & (prescaleCnt_q == PC_MAX) & ~load & ~rst;

    assign q    = count_q;
    assign ovf  = ovf_q;
    assign step = stepInt;
    assign tc   = up ? atTop : atBottom;

    // Next-state: load beats counting; ovf defaults low so it can only ever pulse.
    always_comb begin
        count_d       = count_q;
        prescaleCnt_d = prescaleCnt_q;
        ovf_d         = 1'b0;
        if (load) begin
            prescaleCnt_d = '0;
            if (64'(d) >= MODULUS) begin
                count_d = MAX_VAL;
            end else begin
                count_d = d;
            end
        end else if (en) begin
            if (stepInt) begin
                prescaleCnt_d = '0;
                if (up) begin
                    if (atTop) begin
                        ovf_d   = 1'b1;
                        count_d = SATURATE ? count_q : '0;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end else begin
                    if (atBottom) begin
                        ovf_d   = 1'b1;
                        count_d = SATURATE ? count_q : MAX_VAL;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end else begin
                prescaleCnt_d = prescaleCnt_q + PCW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q       <= '0;
            prescaleCnt_q <= '0;
            ovf_q         <= 1'b0;
        end else begin
            count_q       <= count_d;
            prescaleCnt_q <= prescaleCnt_d;
            ovf_q         <= ovf_d;
        end
    end

endmodule
